// File: rtl/lif_wta_if.sv
// Bundles the neuron-array control inputs and spike/winner outputs.
// The master side drives currents and configuration; the slave side is the array.
interface lif_wta_if #(
    parameter int N     = 4,
    parameter int W     = 8,
    parameter int CUR_W = 4
);
    logic                   en;
    logic [N*CUR_W-1:0]     current;
    logic [W-1:0]           threshold;
    logic [1:0]             leak_shift;
    logic                   wta_mode;
    logic [N-1:0]           spike;
    logic [$clog2(N)-1:0]   winner_idx;
    logic                   winner_valid;
    logic [N-1:0]           state_msb;

    modport master (
        output en, current, threshold, leak_shift, wta_mode,
        input  spike, winner_idx, winner_valid, state_msb
    );

    modport slave (
        input  en, current, threshold, leak_shift, wta_mode,
        output spike, winner_idx, winner_valid, state_msb
    );
endinterface

// File: rtl/lif_wta_array.sv
// Winner-take-all array of leaky integrate-and-fire neurons with shift leak,
// saturating integration, per-neuron refractory counters and a lowest-index-tie arbiter.
module lif_neuron #(
    parameter int W      = 8,
    parameter int CUR_W  = 4,
    parameter int REFRAC = 3,
    parameter int RW     = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic [CUR_W-1:0] cur,
    input  logic [W-1:0]     threshold,
    input  logic [1:0]       leak_shift,
    input  logic             fire,
    input  logic             inhibit,
    output logic [W-1:0]     s,
    output logic             elig
);
    logic [RW-1:0] r;
    logic [W-1:0]  leak;
    logic [W:0]    sum;
    logic [W-1:0]  s_int;

    assign elig  = (r == '0) && (threshold != '0) && (s >= threshold);
    assign leak  = (leak_shift == 2'd0) ? '0 : (s >> leak_shift);
    // leak <= s, so the subtraction stays non-negative in W+1 bits
    assign sum   = {1'b0, s} - {1'b0, leak} + {{(W+1-CUR_W){1'b0}}, cur};
    assign s_int = sum[W] ? '1 : sum[W-1:0];

    always_ff @(posedge clk) begin
        if (rst) begin
            s <= '0;
            r <= '0;
        end else if (en) begin
            if (r != '0) begin
                s <= '0;
                r <= r - 1'b1;
            end else if (fire) begin
                s <= '0;
                r <= RW'(REFRAC);
            end else if (inhibit) begin
                s <= '0;
            end else begin
                s <= s_int;
            end
        end
    end
endmodule

module lif_wta_array #(
    parameter int N      = 4,
    parameter int W      = 8,
    parameter int CUR_W  = 4,
    parameter int REFRAC = 3
) (
    input  logic      clk,
    input  logic      rst,
    lif_wta_if.slave  bus
);
    localparam int IW = $clog2(N);
    localparam int RW = (REFRAC > 0) ? $clog2(REFRAC + 1) : 1;

    logic [N-1:0][W-1:0] s;
    logic [N-1:0]        elig;
    logic [N-1:0]        fire;
    logic [N-1:0]        inhibit;
    logic                found;
    logic [IW-1:0]       best_idx;
    logic [W-1:0]        best_val;
    logic [IW-1:0]       low_idx;

    logic [N-1:0]        spike_q;
    logic [IW-1:0]       widx_q;
    logic                wvalid_q;

    genvar g;
    generate
        for (g = 0; g < N; g++) begin : g_neuron
            lif_neuron #(.W(W), .CUR_W(CUR_W), .REFRAC(REFRAC), .RW(RW)) u_neuron (
                .clk        (clk),
                .rst        (rst),
                .en         (bus.en),
                .cur        (bus.current[g*CUR_W +: CUR_W]),
                .threshold  (bus.threshold),
                .leak_shift (bus.leak_shift),
                .fire       (fire[g]),
                .inhibit    (inhibit[g]),
                .s          (s[g]),
                .elig       (elig[g])
            );
            assign bus.state_msb[g] = s[g][W-1];
        end
    endgenerate

    // Strict '>' keeps the earlier (lower) index on equal membrane values.
    always_comb begin
        found    = 1'b0;
        best_idx = '0;
        best_val = '0;
        for (int i = 0; i < N; i++) begin
            if (elig[i] && (!found || s[i] > best_val)) begin
                found    = 1'b1;
                best_idx = IW'(i);
                best_val = s[i];
            end
        end
    end

    always_comb begin
        fire = '0;
        if (bus.wta_mode) begin
            if (found) fire[best_idx] = 1'b1;
        end else begin
            fire = elig;
        end
        inhibit = (bus.wta_mode && found) ? ~fire : '0;
    end

    always_comb begin
        low_idx = '0;
        for (int i = N - 1; i >= 0; i--) begin
            if (fire[i]) low_idx = IW'(i);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            spike_q  <= '0;
            widx_q   <= '0;
            wvalid_q <= 1'b0;
        end else if (bus.en) begin
            spike_q  <= fire;
            wvalid_q <= |fire;
            if (|fire) widx_q <= low_idx;
        end else begin
            spike_q  <= '0;
            wvalid_q <= 1'b0;
        end
    end

    assign bus.spike        = spike_q;
    assign bus.winner_idx   = widx_q;
    assign bus.winner_valid = wvalid_q;
endmodule
